// File: rtl/imuldiv_iter_muldiv_param_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imuldiv_iter_muldiv_param_pkg
// Description : Shared definitions for the iterative multiply/divide unit:
//               function encodings, FSM state encodings, the request-message
//               field layout {fn, a, b, tag} expressed in terms of W/TAG_W,
//               and small function-decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package imuldiv_iter_muldiv_param_pkg;

    // Request function encodings (5-7 are reserved and behave as mul)
    localparam logic [2:0] c_IMULDIV_MULDIVREQ_MSG_FUNC_MUL  = 3'd0;
    localparam logic [2:0] c_IMULDIV_MULDIVREQ_MSG_FUNC_DIV  = 3'd1;
    localparam logic [2:0] c_IMULDIV_MULDIVREQ_MSG_FUNC_DIVU = 3'd2;
    localparam logic [2:0] c_IMULDIV_MULDIVREQ_MSG_FUNC_REM  = 3'd3;
    localparam logic [2:0] c_IMULDIV_MULDIVREQ_MSG_FUNC_REMU = 3'd4;

    // FSM state encodings
    localparam int         c_STATE_W    = 2;
    localparam logic [1:0] c_STATE_IDLE = 2'd0;
    localparam logic [1:0] c_STATE_CALC = 2'd1;
    localparam logic [1:0] c_STATE_DONE = 2'd2;

    localparam int c_FN_W = 3;

    // Packed request layout, LSB first: tag, b, a, fn
    function automatic int req_msg_tag_lsb(input int w, input int tag_w);
        return 0;
    endfunction

    function automatic int req_msg_b_lsb(input int w, input int tag_w);
        return tag_w;
    endfunction

    function automatic int req_msg_a_lsb(input int w, input int tag_w);
        return tag_w + w;
    endfunction

    function automatic int req_msg_fn_lsb(input int w, input int tag_w);
        return tag_w + 2 * w;
    endfunction

    function automatic int req_msg_width(input int w, input int tag_w);
        return c_FN_W + 2 * w + tag_w;
    endfunction

    // True for the divide/remainder family
    function automatic logic fn_is_div(input logic [2:0] fn);
        return (fn == c_IMULDIV_MULDIVREQ_MSG_FUNC_DIV)  ||
               (fn == c_IMULDIV_MULDIVREQ_MSG_FUNC_DIVU) ||
               (fn == c_IMULDIV_MULDIVREQ_MSG_FUNC_REM)  ||
               (fn == c_IMULDIV_MULDIVREQ_MSG_FUNC_REMU);
    endfunction

    // Everything except divu/remu treats operands as two's complement
    function automatic logic fn_is_signed(input logic [2:0] fn);
        return !((fn == c_IMULDIV_MULDIVREQ_MSG_FUNC_DIVU) ||
                 (fn == c_IMULDIV_MULDIVREQ_MSG_FUNC_REMU));
    endfunction

endpackage
`default_nettype wire

// File: rtl/imuldiv_iter_muldiv_param_sign_mag.sv
`default_nettype none
// ============================================================================
// Module      : imuldiv_iter_muldiv_param_sign_mag
// Description : Combinational conditional two's-complement negate. Used as
//               |x| on operand capture (negate = signed & msb) and as the
//               final sign correction of product, quotient and remainder.
// Ports       : i_value  [N-1:0]  value in
//               i_negate           1 = output the two's complement negation
//               o_value  [N-1:0]  value out
// Revision    : 1.0 - initial release
// ============================================================================
module imuldiv_iter_muldiv_param_sign_mag #(
    parameter int N = 32
) (
    input  logic [N-1:0] i_value,
    input  logic         i_negate,
    output logic [N-1:0] o_value
);

    // Negating the most negative value yields itself, which is exactly the
    // unsigned magnitude |MIN| and the correct MIN/-1 quotient.
    assign o_value = i_negate ? -i_value : i_value;

endmodule
`default_nettype wire

// File: rtl/imuldiv_iter_muldiv_param.sv
`default_nettype none
// ============================================================================
// Module      : imuldiv_iter_muldiv_param
// Description : Iterative radix-2 integer multiply/divide unit with val/rdy
//               request and response interfaces. mul is a shift-add over a
//               2W accumulator; div/divu/rem/remu use restoring division on
//               magnitudes with a registered sign correction at the end.
//               Div-by-zero returns quot = all ones, rem = a.
// Ports       : clk, reset (sync, active-high)
//               muldivreq_msg_fn/a/b/tag, muldivreq_val, muldivreq_rdy
//               muldivresp_msg_result [2W-1:0] (mul: product, div: {rem,quot})
//               muldivresp_msg_tag, muldivresp_val, muldivresp_rdy
// Config      : IMULDIV_ITER_EARLY_OUT_EN - when defined, mul finishes as
//               soon as the remaining multiplier bits are all zero.
// Revision    : 1.0 - initial release
// ============================================================================
module imuldiv_iter_muldiv_param
    import imuldiv_iter_muldiv_param_pkg::*;
#(
    parameter int W     = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       muldivreq_msg_fn,
    input  logic [W-1:0]     muldivreq_msg_a,
    input  logic [W-1:0]     muldivreq_msg_b,
    input  logic [TAG_W-1:0] muldivreq_msg_tag,
    input  logic             muldivreq_val,
    output logic             muldivreq_rdy,
    output logic [2*W-1:0]   muldivresp_msg_result,
    output logic [TAG_W-1:0] muldivresp_msg_tag,
    output logic             muldivresp_val,
    input  logic             muldivresp_rdy
);

    localparam int c_CNT_W = $clog2(W + 1);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_next;

    logic [c_CNT_W-1:0]   r_count;
    logic                 r_is_div;
    logic                 r_sign_a;
    logic                 r_sign_b;
    logic                 r_b_zero;
    logic [TAG_W-1:0]     r_tag;
    logic [2*W-1:0]       r_result;
    logic [2*W-1:0]       r_acc;     // mul accumulator
    logic [2*W-1:0]       r_mcand;   // mul: |a| shifted left each step
    logic [W-1:0]         r_x;       // mul: remaining multiplier; div: dividend->quotient
    logic [W-1:0]         r_y;       // div: divisor magnitude
    logic [W-1:0]         r_rem;     // div: partial remainder

    // ------------------------------------------------------------------
    // Operand capture
    // ------------------------------------------------------------------
    logic         w_req_signed;
    logic         w_neg_a;
    logic         w_neg_b;
    logic [W-1:0] w_abs_a;
    logic [W-1:0] w_abs_b;
    logic         w_accept;

    assign w_req_signed = fn_is_signed(muldivreq_msg_fn);
    assign w_neg_a      = w_req_signed & muldivreq_msg_a[W-1];
    assign w_neg_b      = w_req_signed & muldivreq_msg_b[W-1];
    assign w_accept     = muldivreq_val && (r_state == c_STATE_IDLE);

    imuldiv_iter_muldiv_param_sign_mag #(.N(W)) u_abs_a (
        .i_value  (muldivreq_msg_a),
        .i_negate (w_neg_a),
        .o_value  (w_abs_a)
    );

    imuldiv_iter_muldiv_param_sign_mag #(.N(W)) u_abs_b (
        .i_value  (muldivreq_msg_b),
        .i_negate (w_neg_b),
        .o_value  (w_abs_b)
    );

    // ------------------------------------------------------------------
    // One iteration step
    // ------------------------------------------------------------------
    logic [2*W-1:0] w_acc_next;
    logic [W-1:0]   w_x_shr;
    logic [W:0]     w_rem_sh;
    logic [W:0]     w_diff;
    logic           w_fits;
    logic [W-1:0]   w_rem_next;
    logic [W-1:0]   w_quot_next;
    logic           w_early;
    logic           w_last;

    assign w_acc_next  = r_x[0] ? (r_acc + r_mcand) : r_acc;
    assign w_x_shr     = r_x >> 1;

    // Restoring step: bring in the next dividend bit, keep the subtraction
    // only if it did not borrow (diff MSB clear).
    assign w_rem_sh    = {r_rem, r_x[W-1]};
    assign w_diff      = w_rem_sh - {1'b0, r_y};
    assign w_fits      = ~w_diff[W];
    assign w_rem_next  = w_fits ? w_diff[W-1:0] : w_rem_sh[W-1:0];
    assign w_quot_next = {r_x[W-2:0], w_fits};

`ifdef IMULDIV_ITER_EARLY_OUT_EN
    // Remaining multiplier bits all zero: the accumulator is already final
    assign w_early = !r_is_div && (w_x_shr == '0);
`else
    assign w_early = 1'b0;
`endif

    assign w_last = (r_count == c_CNT_W'(1)) || w_early;

    // ------------------------------------------------------------------
    // Sign correction of the final step's values
    // ------------------------------------------------------------------
    logic [2*W-1:0] w_prod_fixed;
    logic [W-1:0]   w_quot_fixed;
    logic [W-1:0]   w_rem_fixed;
    logic [W-1:0]   w_quot_out;
    logic [2*W-1:0] w_result_final;

    imuldiv_iter_muldiv_param_sign_mag #(.N(2*W)) u_fix_prod (
        .i_value  (w_acc_next),
        .i_negate (r_sign_a ^ r_sign_b),
        .o_value  (w_prod_fixed)
    );

    imuldiv_iter_muldiv_param_sign_mag #(.N(W)) u_fix_quot (
        .i_value  (w_quot_next),
        .i_negate (r_sign_a ^ r_sign_b),
        .o_value  (w_quot_fixed)
    );

    // With a zero divisor the remainder path accumulates |a|; restoring
    // sign(a) turns it back into raw a, so only the quotient needs forcing.
    imuldiv_iter_muldiv_param_sign_mag #(.N(W)) u_fix_rem (
        .i_value  (w_rem_next),
        .i_negate (r_sign_a),
        .o_value  (w_rem_fixed)
    );

    assign w_quot_out     = r_b_zero ? {W{1'b1}} : w_quot_fixed;
    assign w_result_final = r_is_div ? {w_rem_fixed, w_quot_out} : w_prod_fixed;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_STATE_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        muldivreq_rdy  = 1'b0;
        muldivresp_val = 1'b0;
        case (r_state)
            c_STATE_IDLE: begin
                muldivreq_rdy = 1'b1;
                if (muldivreq_val) begin
                    w_state_next = c_STATE_CALC;
                end
            end
            c_STATE_CALC: begin
                if (w_last) begin
                    w_state_next = c_STATE_DONE;
                end
            end
            c_STATE_DONE: begin
                muldivresp_val = 1'b1;
                if (muldivresp_rdy) begin
                    w_state_next = c_STATE_IDLE;
                end
            end
            default: begin
                w_state_next = c_STATE_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= '0;
            r_is_div <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_b_zero <= 1'b0;
            r_tag    <= '0;
            r_result <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_rem    <= '0;
        end else if (w_accept) begin
            r_count  <= c_CNT_W'(W);
            r_is_div <= fn_is_div(muldivreq_msg_fn);
            r_sign_a <= w_neg_a;
            r_sign_b <= w_neg_b;
            r_b_zero <= (muldivreq_msg_b == '0);
            r_tag    <= muldivreq_msg_tag;
            r_acc    <= '0;
            r_mcand  <= {{W{1'b0}}, w_abs_a};
            r_x      <= fn_is_div(muldivreq_msg_fn) ? w_abs_a : w_abs_b;
            r_y      <= w_abs_b;
            r_rem    <= '0;
        end else if (r_state == c_STATE_CALC) begin
            r_count <= r_count - c_CNT_W'(1);
            r_acc   <= w_acc_next;
            r_mcand <= r_mcand << 1;
            r_x     <= r_is_div ? w_quot_next : w_x_shr;
            r_rem   <= w_rem_next;
            if (w_last) begin
                r_result <= w_result_final;
            end
        end
    end

    assign muldivresp_msg_result = r_result;
    assign muldivresp_msg_tag    = r_tag;

endmodule
`default_nettype wire

// File: tb/tb_imuldiv_iter_muldiv_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_imuldiv_iter_muldiv_param
// Description : Directed self-checking bench for imuldiv_iter_muldiv_param
//               (W=32, TAG_W=4). Hand-computed vectors for every function,
//               div-by-zero/overflow corners, tag return, back-pressure,
//               mid-operation reset and response latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imuldiv_iter_muldiv_param;

    localparam int W     = 32;
    localparam int TAG_W = 4;

    logic             clk;
    logic             reset;
    logic [2:0]       muldivreq_msg_fn;
    logic [W-1:0]     muldivreq_msg_a;
    logic [W-1:0]     muldivreq_msg_b;
    logic [TAG_W-1:0] muldivreq_msg_tag;
    logic             muldivreq_val;
    logic             muldivreq_rdy;
    logic [2*W-1:0]   muldivresp_msg_result;
    logic [TAG_W-1:0] muldivresp_msg_tag;
    logic             muldivresp_val;
    logic             muldivresp_rdy;

    int n_vec  = 0;
    int n_miss = 0;

    imuldiv_iter_muldiv_param #(.W(W), .TAG_W(TAG_W)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .muldivreq_msg_fn      (muldivreq_msg_fn),
        .muldivreq_msg_a       (muldivreq_msg_a),
        .muldivreq_msg_b       (muldivreq_msg_b),
        .muldivreq_msg_tag     (muldivreq_msg_tag),
        .muldivreq_val         (muldivreq_val),
        .muldivreq_rdy         (muldivreq_rdy),
        .muldivresp_msg_result (muldivresp_msg_result),
        .muldivresp_msg_tag    (muldivresp_msg_tag),
        .muldivresp_val        (muldivresp_val),
        .muldivresp_rdy        (muldivresp_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected cycle of first resp_val, counting the accept cycle as 0
    function automatic int exp_lat(input logic [2:0] fn, input logic [31:0] b);
        int lat;
`ifdef IMULDIV_ITER_EARLY_OUT_EN
        logic [31:0] mb;
`endif
        lat = 33;
`ifdef IMULDIV_ITER_EARLY_OUT_EN
        if (!(fn inside {3'd1, 3'd2, 3'd3, 3'd4})) begin
            mb  = b[31] ? -b : b;
            lat = 2;
            for (int i = 0; i < 32; i++) if (mb[i]) lat = 2 + i;
        end
`endif
        return lat;
    endfunction

    task automatic send_req(input string name, input logic [2:0] fn, input logic [31:0] a,
                            input logic [31:0] b, input logic [3:0] tag);
        @(negedge clk);
        muldivreq_msg_fn  = fn;
        muldivreq_msg_a   = a;
        muldivreq_msg_b   = b;
        muldivreq_msg_tag = tag;
        muldivreq_val     = 1'b1;
        chk({name, ".req_rdy"}, 64'(muldivreq_rdy), 64'd1);
        @(posedge clk);
        #1;
        muldivreq_val = 1'b0;
    endtask

    // Returns the cycle index at which resp_val was first seen (0 = accept)
    task automatic wait_resp(input string name, output int cyc);
        cyc = 1;
        while (!muldivresp_val && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({name, ".timeout"}, 64'(muldivresp_val), 64'd1);
    endtask

    task automatic do_op(input string name, input logic [2:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] tag, input logic [63:0] exp);
        int cyc;
        send_req(name, fn, a, b, tag);
        wait_resp(name, cyc);
        chk({name, ".result"}, muldivresp_msg_result, exp);
        chk({name, ".tag"}, 64'(muldivresp_msg_tag), 64'(tag));
        chk({name, ".latency"}, 64'(cyc), 64'(exp_lat(fn, b)));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        int unstable;
        int saw_resp;
        logic [63:0] held;

        reset             = 1'b1;
        muldivreq_msg_fn  = '0;
        muldivreq_msg_a   = '0;
        muldivreq_msg_b   = '0;
        muldivreq_msg_tag = '0;
        muldivreq_val     = 1'b0;
        muldivresp_rdy    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.req_rdy",  64'(muldivreq_rdy), 64'd1);
        chk("reset.resp_val", 64'(muldivresp_val), 64'd0);
        chk("reset.result",   muldivresp_msg_result, 64'd0);
        chk("reset.tag",      64'(muldivresp_msg_tag), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // mul
        do_op("mul_m1x1",   3'd0, 32'hffffffff, 32'h00000001, 4'h1, 64'hffffffff_ffffffff);
        do_op("mul_m8xm8",  3'd0, 32'hfffffff8, 32'hfffffff8, 4'h5, 64'h00000000_00000040);
        do_op("mul_dbef",   3'd0, 32'hdeadbeef, 32'h10000000, 4'h2, 64'hfdeadbee_f0000000);
        do_op("mul_minmin", 3'd0, 32'h80000000, 32'h80000000, 4'h3, 64'h40000000_00000000);
        do_op("mul_3x2",    3'd0, 32'h00000003, 32'h00000002, 4'h4, 64'h00000000_00000006);
        do_op("mul_rsvd5",  3'd5, 32'h00000003, 32'hfffffffe, 4'h6, 64'hffffffff_fffffffa);
        do_op("mul_x0",     3'd7, 32'h12345678, 32'h00000000, 4'h7, 64'h00000000_00000000);

        // signed div / rem
        do_op("div_s",      3'd1, 32'h0a01b044, 32'hffffb14a, 4'h8, 64'h00003372_ffffdf75);
        do_op("rem_s",      3'd3, 32'hdeadbeef, 32'h0000beef, 4'h9, 64'hffffda72_ffffd353);
        do_op("div_s2",     3'd1, 32'hdeadbeef, 32'h0000beef, 4'ha, 64'hffffda72_ffffd353);

        // unsigned div / rem
        do_op("divu",       3'd2, 32'hdeadbeef, 32'h0000beef, 4'hb, 64'h0000227f_00012a90);
        do_op("remu",       3'd4, 32'hf5fe4fbc, 32'hffffb14a, 4'hc, 64'hf5fe4fbc_00000000);

        // corners
        do_op("div_by0",    3'd1, 32'h00000007, 32'h00000000, 4'hd, 64'h00000007_ffffffff);
        do_op("div_nby0",   3'd1, 32'hfffffff9, 32'h00000000, 4'he, 64'hfffffff9_ffffffff);
        do_op("div_ovf",    3'd1, 32'h80000000, 32'hffffffff, 4'hf, 64'h00000000_80000000);
        do_op("divu_0by0",  3'd2, 32'h00000000, 32'h00000000, 4'h0, 64'h00000000_ffffffff);

        // back-pressure: hold resp_rdy low for 20 cycles
        muldivresp_rdy = 1'b0;
        send_req("bp", 3'd1, 32'h00000064, 32'h00000007, 4'h5);
        wait_resp("bp", cyc);
        held = muldivresp_msg_result;
        chk("bp.result", held, 64'h00000002_0000000e);
        unstable = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (muldivresp_msg_result !== held || !muldivresp_val ||
                muldivreq_rdy || muldivresp_msg_tag !== 4'h5) unstable++;
        end
        chk("bp.stable", 64'(unstable), 64'd0);
        chk("bp.req_rdy", 64'(muldivreq_rdy), 64'd0);
        @(negedge clk);
        muldivresp_rdy = 1'b1;
        @(posedge clk);
        #1;
        chk("bp.released", 64'(muldivresp_val), 64'd0);
        chk("bp.idle_rdy", 64'(muldivreq_rdy), 64'd1);

        // reset during CALC abandons the operation
        send_req("rst", 3'd0, 32'h00001234, 32'h00005678, 4'h9);
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst.req_rdy",  64'(muldivreq_rdy), 64'd1);
        chk("rst.resp_val", 64'(muldivresp_val), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        saw_resp = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (muldivresp_val) saw_resp++;
        end
        chk("rst.no_resp", 64'(saw_resp), 64'd0);

        // unit still works after the abandoned operation
        do_op("post_rst", 3'd0, 32'h00000003, 32'h00000002, 4'h5, 64'h00000000_00000006);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
